nonce_arbiter: RTL and testbench

Controller that owns the `rng` nonce generator and shares it among `NUM_REQ` requesters (session/encryption units). It initialises the generator after reset and grants nonces round-robin, one per grant. It advances the generator exactly once per issued nonce and guarantees no nonce is issued twice. It halts permanently on counter wrap-around or on a generator/shadow mismatch.

---
 rtl/nonce_arbiter.sv | 159 +++++++++++++++
 tb/tb_nonce_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_arbiter.sv
// Shares one nonce generator among NUM_REQ requesters, round-robin.
// Shadows the generator count so no nonce is issued twice; halts on wrap or mismatch.
module nonce_arbiter #(
  parameter int WORDSIZE               = 32,
  parameter int NUM_REQ                = 4,
  parameter int NONCE_INCREMENT_OFFSET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [WORDSIZE-1:0] nonce_out,
  output logic                nonce_valid,
  output logic                rng_en,
  output logic                rng_reset,
  input  logic [WORDSIZE-1:0] rng_data,
  input  logic                rng_ready,
  output logic                busy,
  output logic                exhausted,
  output logic                error
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_REQ - 1);
  localparam logic [WORDSIZE:0] OFF_W =
    (WORDSIZE+1)'(NONCE_INCREMENT_OFFSET);

  typedef enum logic [2:0] {
    S_RST_RNG,
    S_WAIT_RDY,
    S_IDLE,
    S_SETTLE,
    S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [WORDSIZE-1:0]   shadow_q, shadow_d;
  logic [LW-1:0]         last_q, last_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [WORDSIZE-1:0]   nonce_q, nonce_d;
  logic                  valid_q, valid_d;
  logic                  en_q, en_d;
  logic                  rrst_q, rrst_d;
  logic                  busy_q, busy_d;
  logic                  exh_q, exh_d;
  logic                  err_q, err_d;

  logic [LW-1:0]         win;
  logic                  found;
  logic [WORDSIZE:0]     sum;

  assign sum = {1'b0, shadow_q} + OFF_W;

  // Walk from the farthest offset down so the nearest to last+1 wins.
  always_comb begin
    int idx;
    logic [LW-1:0] k;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    k     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      k   = LW'(idx);
      if (req[k]) begin
        win   = k;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    last_d   = last_q;
    gnt_d    = '0;
    nonce_d  = nonce_q;
    valid_d  = 1'b0;
    en_d     = 1'b0;
    rrst_d   = 1'b0;
    exh_d    = exh_q;
    err_d    = err_q;
    unique case (state_q)
      S_RST_RNG: begin
        shadow_d = '0;
        state_d  = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (rng_ready) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (found) begin
          if (rng_data != shadow_q) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            gnt_d    = NUM_REQ'(1) << win;
            valid_d  = 1'b1;
            nonce_d  = rng_data;
            last_d   = win;
            shadow_d = sum[WORDSIZE-1:0];
            if (sum[WORDSIZE]) begin
              exh_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              en_d    = 1'b1;
              state_d = S_SETTLE;
            end
          end
        end
      end
      S_SETTLE: state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d = S_RST_RNG;
        rrst_d  = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_RST_RNG;
      shadow_q <= '0;
      last_q   <= LAST_RST;
      gnt_q    <= '0;
      nonce_q  <= '0;
      valid_q  <= 1'b0;
      en_q     <= 1'b0;
      rrst_q   <= 1'b1;
      busy_q   <= 1'b1;
      exh_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      nonce_q  <= nonce_d;
      valid_q  <= valid_d;
      en_q     <= en_d;
      rrst_q   <= rrst_d;
      busy_q   <= busy_d;
      exh_q    <= exh_d;
      err_q    <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign nonce_out   = nonce_q;
  assign nonce_valid = valid_q;
  assign rng_en      = en_q;
  assign rng_reset   = rrst_q;
  assign busy        = busy_q;
  assign exhausted   = exh_q;
  assign error       = err_q;

endmodule

// File: tb/tb_nonce_arbiter.sv
// Bench for nonce_arbiter: two instances (step 1 and step 3) with generator models,
// directed vector table plus random requests against a round-robin reference.
module tb_nonce_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         force_bad;
  logic [N-1:0] req1, req3, gnt1, gnt3;
  logic [W-1:0] nonce1, nonce3, rdata1, rdata3;
  logic [W-1:0] g1_q, g3_q;
  logic         valid1, valid3, en1, en3, rr1, rr3;
  logic         rdy1, rdy3, busy1, busy3;
  logic         exh1, exh3, err1, err3;

  int vectors = 0;
  int miscompares = 0;

  nonce_arbiter #(
    .WORDSIZE(W), .NUM_REQ(N), .NONCE_INCREMENT_OFFSET(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .gnt(gnt1),
    .nonce_out(nonce1), .nonce_valid(valid1), .rng_en(en1),
    .rng_reset(rr1), .rng_data(rdata1), .rng_ready(rdy1),
    .busy(busy1), .exhausted(exh1), .error(err1)
  );

  nonce_arbiter #(
    .WORDSIZE(W), .NUM_REQ(N), .NONCE_INCREMENT_OFFSET(3)
  ) u_dut3 (
    .clk(clk), .reset(reset), .req(req3), .gnt(gnt3),
    .nonce_out(nonce3), .nonce_valid(valid3), .rng_en(en3),
    .rng_reset(rr3), .rng_data(rdata3), .rng_ready(rdy3),
    .busy(busy3), .exhausted(exh3), .error(err3)
  );

  // Generator models: sync active-high reset, ready one edge after release.
  always @(posedge clk) begin
    if (rr1) begin
      g1_q <= '0;
      rdy1 <= 1'b0;
    end else begin
      rdy1 <= 1'b1;
      if (en1) g1_q <= g1_q + 8'd1;
    end
  end

  always @(posedge clk) begin
    if (rr3) begin
      g3_q <= '0;
      rdy3 <= 1'b0;
    end else begin
      rdy3 <= 1'b1;
      if (en3) g3_q <= g3_q + 8'd3;
    end
  end

  assign rdata1 = force_bad ? 8'd5 : g1_q;
  assign rdata3 = g3_q;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [W-1:0] nonce;
  } vec_t;

  vec_t rr_tab[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst_vals();
    chk("rst_gnt", 32'(gnt1), 0);
    chk("rst_nonce", 32'(nonce1), 0);
    chk("rst_valid", 32'(valid1), 0);
    chk("rst_rng_en", 32'(en1), 0);
    chk("rst_rng_reset", 32'(rr1), 1);
    chk("rst_busy", 32'(busy1), 1);
    chk("rst_exhausted", 32'(exh1), 0);
    chk("rst_error", 32'(err1), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req1  = '0;
    req3  = '0;
    repeat (3) tick();
    check_rst_vals();
    reset = 1'b1;
    chk("rng_reset_at_release", 32'(rr1), 1);
    tick();
    chk("e1_rng_reset", 32'(rr1), 0);
    chk("e1_busy", 32'(busy1), 1);
    tick();
    chk("e2_busy", 32'(busy1), 1);
    tick();
    chk("e3_busy", 32'(busy1), 0);
    chk("e3_gnt", 32'(gnt1), 0);
    chk("e3_valid", 32'(valid1), 0);
    chk("e3_rng_en", 32'(en1), 0);
    chk("e3_rng_reset", 32'(rr1), 0);
  endtask

  task automatic do_grant(input logic [N-1:0] r, input logic [N-1:0] eg,
                          input logic [W-1:0] en);
    req1 = r;
    tick();
    chk("grant_gnt", 32'(gnt1), 32'(eg));
    chk("grant_valid", 32'(valid1), 1);
    chk("grant_nonce", 32'(nonce1), 32'(en));
    chk("grant_rng_en", 32'(en1), 1);
    chk("grant_rng_reset", 32'(rr1), 0);
    tick();
    chk("settle_gnt", 32'(gnt1), 0);
    chk("settle_valid", 32'(valid1), 0);
    chk("settle_rng_en", 32'(en1), 0);
    chk("settle_nonce_hold", 32'(nonce1), 32'(en));
  endtask

  initial begin
    int cnt;
    int last;
    int w;
    bit cool;
    bit exh_seen;
    logic [N-1:0] r;
    logic [N-1:0] eg;

    rr_tab[0] = '{4'b1111, 4'b0001, 8'd0};
    rr_tab[1] = '{4'b1111, 4'b0010, 8'd1};
    rr_tab[2] = '{4'b1111, 4'b0100, 8'd2};
    rr_tab[3] = '{4'b1111, 4'b1000, 8'd3};
    rr_tab[4] = '{4'b1111, 4'b0001, 8'd4};
    rr_tab[5] = '{4'b1111, 4'b0010, 8'd5};
    rr_tab[6] = '{4'b1010, 4'b1000, 8'd6};

    force_bad = 1'b0;
    reset = 1'b0;
    req1 = '0;
    req3 = '0;

    // single requester
    do_reset();
    for (int i = 0; i < 3; i++) do_grant(4'b0001, 4'b0001, W'(i));

    // round robin table
    do_reset();
    for (int i = 0; i < 7; i++)
      do_grant(rr_tab[i].req, rr_tab[i].gnt, rr_tab[i].nonce);

    // mismatch halts without a grant
    do_reset();
    force_bad = 1'b1;
    req1 = 4'b0001;
    tick();
    chk("mm_gnt", 32'(gnt1), 0);
    chk("mm_valid", 32'(valid1), 0);
    chk("mm_error", 32'(err1), 1);
    chk("mm_busy", 32'(busy1), 1);
    chk("mm_rng_en", 32'(en1), 0);
    force_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_gnt", 32'(gnt1), 0);
      chk("halt_error", 32'(err1), 1);
      chk("halt_rng_en", 32'(en1), 0);
      chk("halt_busy", 32'(busy1), 1);
    end
    do_reset();

    // reset during SETTLE after nonce 7
    for (int i = 0; i < 7; i++) do_grant(4'b0001, 4'b0001, W'(i));
    req1 = 4'b0001;
    tick();
    chk("pre_rst_nonce", 32'(nonce1), 7);
    chk("pre_rst_gnt", 32'(gnt1), 1);
    reset = 1'b0;
    tick();
    check_rst_vals();
    do_reset();
    do_grant(4'b0001, 4'b0001, 8'd0);

    // exhaustion with step 3
    do_reset();
    req3 = 4'b0001;
    cnt = 0;
    exh_seen = 1'b0;
    for (int c = 0; c < 220; c++) begin
      tick();
      if (gnt3 != '0) begin
        chk("exh_after_halt_gnt", 32'(exh_seen), 0);
        chk("exh_gnt", 32'(gnt3), 1);
        chk("exh_nonce", 32'(nonce3), 32'(cnt * 3));
        chk("exh_flag", 32'(exh3), 32'(cnt == 85));
        chk("exh_rng_en", 32'(en3), 32'(cnt != 85));
        cnt++;
        if (exh3) exh_seen = 1'b1;
      end else if (exh_seen) begin
        chk("exh_halt_rng_en", 32'(en3), 0);
      end
    end
    chk("exh_count", 32'(cnt), 86);
    chk("exh_sticky", 32'(exh3), 1);
    chk("exh_busy", 32'(busy3), 1);
    chk("exh_error", 32'(err3), 0);
    req3 = '0;

    // random requests vs round-robin reference
    do_reset();
    last = N - 1;
    cnt  = 0;
    cool = 1'b0;
    for (int c = 0; c < 300; c++) begin
      r = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = '0;
      req1 = r;
      tick();
      eg = '0;
      if (!cool && r != '0) begin
        w = -1;
        for (int i = 1; i <= N; i++)
          if (w < 0 && r[(last + i) % N]) w = (last + i) % N;
        eg = N'(1) << w;
        chk("rnd_nonce", 32'(nonce1), 32'(cnt));
        cnt++;
        last = w;
        cool = 1'b1;
      end else begin
        cool = 1'b0;
      end
      chk("rnd_gnt", 32'(gnt1), 32'(eg));
      chk("rnd_valid", 32'(valid1), 32'(eg != '0));
      chk("rnd_rng_en", 32'(en1), 32'(eg != '0));
      chk("rnd_error", 32'(err1), 0);
    end
    req1 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
